// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Size encodings, state codes and helpers shared by the LSU files.
// Revision : 1.0
// ============================================================================
package load_store_unit_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF    = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD    = 2'b10;
    localparam logic       LSU_RESET_ACTIVE = 1'b0;

    typedef enum logic [0:0] {
        LSU_ST_IDLE  = 1'b0,
        LSU_ST_WRITE = 1'b1
    } lsu_state_e;

    // Size 2'b11 falls into the word branch.
    function automatic logic lsu_is_misaligned(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_SIZE_BYTE: mis = 1'b0;
            LSU_SIZE_HALF: mis = addr_lo[0];
            default:       mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Little-endian lane extraction/extension for loads and lane merge
//            of sub-word store data into the current memory word.
// Revision : 1.0
// ============================================================================
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic [31:0] merge_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte     = rdata[{addr_lo, 3'b000} +: 8];
        w_half     = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_word  = rdata;
        merge_word = wdata;
        case (size)
            LSU_SIZE_BYTE: begin
                load_word  = {{24{~is_unsigned & w_byte[7]}}, w_byte};
                merge_word = rdata;
                merge_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            LSU_SIZE_HALF: begin
                load_word  = {{16{~is_unsigned & w_half[15]}}, w_half};
                merge_word = rdata;
                merge_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                load_word  = rdata;
                merge_word = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Byte-to-word address LSU with sub-word loads and two-cycle
//            read-modify-write sub-word stores. Optional misaligned-access
//            trap enabled by defining LSU_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_exc,
`endif
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    lsu_state_e            state_q, state_d;
    logic [MEM_ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0]     merge_q, merge_d;

    logic [MEM_ADDR_W-1:0] w_word_idx;
    logic [DATA_W-1:0]     w_load_word;
    logic [DATA_W-1:0]     w_merge_word;
    logic                  w_misalign;
    logic                  w_unused_addr_hi;

    // High address bits are dropped so accesses wrap within memory.
    assign w_word_idx       = req_addr[MEM_ADDR_W+1:2];
    assign w_unused_addr_hi = &{1'b0, req_addr[ADDR_W-1:MEM_ADDR_W+2]};

    lsu_lane_align u_lane_align (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .addr_lo     (req_addr[1:0]),
        .rdata       (mem_rdata),
        .wdata       (req_wdata),
        .load_word   (w_load_word),
        .merge_word  (w_merge_word)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign   = lsu_is_misaligned(req_size, req_addr[1:0]);
    assign misalign_exc = (rst != LSU_RESET_ACTIVE) && (state_q == LSU_ST_IDLE)
                          && req_valid && w_misalign;
`else
    assign w_misalign   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        merge_d   = merge_q;
        stall     = 1'b0;
        mem_write = 1'b0;
        load_data = '0;
        mem_addr  = w_word_idx;
        mem_wdata = req_wdata;
        if (rst != LSU_RESET_ACTIVE) begin
            if (state_q == LSU_ST_WRITE) begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                state_d   = LSU_ST_IDLE;
            end else if (req_valid && !w_misalign) begin
                if (!req_write) begin
                    load_data = w_load_word;
                end else if (req_size[1]) begin
                    mem_write = 1'b1;
                end else begin
                    // Merge now against the current word, commit next cycle.
                    stall   = 1'b1;
                    addr_d  = w_word_idx;
                    merge_d = w_merge_word;
                    state_d = LSU_ST_WRITE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == LSU_RESET_ACTIVE) begin
            state_q <= LSU_ST_IDLE;
            addr_q  <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a memory model and a
//            reference model of loads/stores over a shadow memory array.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 17;
    localparam int MEM_WORDS  = 1 << MEM_ADDR_W;

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  stall;
    logic [DATA_W-1:0]     load_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  misalign_exc;
`endif
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    load_store_unit #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_data    (load_data),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_exc (misalign_exc),
`endif
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory attached to the DUT
    logic [31:0] mem [MEM_WORDS];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    // Reference shadow memory, updated when a store is issued
    logic [31:0] ref_mem [MEM_WORDS];

    typedef struct { logic stall; logic exc; } cyc_t;
    typedef struct { logic [16:0] idx; logic [31:0] data; } wr_t;
    cyc_t        cyc_q[$];
    wr_t         wr_q[$];
    logic [31:0] ld_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned word_index(input logic [31:0] a);
        return (a / 4) % MEM_WORDS;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic uns, input logic [31:0] a);
        logic [31:0] v;
        if (size >= 2) return word;
        if (size == 0) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else begin
            v = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [31:0] wd, input logic [31:0] a);
        logic [31:0] mask;
        int          sh;
        if (size >= 2) return wd;
        mask = (size == 0) ? 32'hFF : 32'hFFFF;
        sh   = (size == 0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // ---------------- driver ----------------
    task automatic push_cyc(input logic s, input logic e);
        cyc_t c;
        c.stall = s;
        c.exc   = e;
        cyc_q.push_back(c);
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx;
        wr_t         w;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        idx = word_index(a);
        if (model_misaligned(size, a)) begin
            push_cyc(1'b0, 1'b1);
            if (!wr) ld_q.push_back(32'h0);
        end else if (!wr) begin
            push_cyc(1'b0, 1'b0);
            ld_q.push_back(model_load(ref_mem[idx], size, uns, a));
        end else begin
            w.idx  = idx[16:0];
            w.data = model_store(ref_mem[idx], size, wd, a);
            wr_q.push_back(w);
            ref_mem[idx] = w.data;
            if (size >= 2) begin
                push_cyc(1'b0, 1'b0);
            end else begin
                push_cyc(1'b1, 1'b0);
                @(posedge clk); #1;
                push_cyc(1'b0, 1'b0);
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom_range(0, 1);
        req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
        push_cyc(1'b0, 1'b0);
    endtask

    // Sub-word store interrupted by reset while in the write cycle
    task automatic aborted_store(input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = a; req_wdata = wd;
        push_cyc(1'b1, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0;
        push_cyc(1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    cyc_t        mon_c;
    wr_t         mon_w;
    logic [31:0] mon_ld;

    initial begin
        forever begin
            @(negedge clk);
            if (rst == 1'b0) begin
                check("reset_mem_write", {31'b0, mem_write}, 32'h0);
                check("reset_stall", {31'b0, stall}, 32'h0);
                check("reset_load_data", load_data, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
                check("reset_misalign_exc", {31'b0, misalign_exc}, 32'h0);
`endif
            end else begin
                if (cyc_q.size() == 0) begin
                    flag("cycle_queue", "DUT cycle with no expectation queued");
                end else begin
                    mon_c = cyc_q.pop_front();
                    check("stall", {31'b0, stall}, {31'b0, mon_c.stall});
`ifdef LSU_MISALIGN_TRAP_EN
                    check("misalign_exc", {31'b0, misalign_exc}, {31'b0, mon_c.exc});
`endif
                end
                if (mem_write) begin
                    if (wr_q.size() == 0) begin
                        flag("unexpected_write", $sformatf("write to 0x%05h, expected none", mem_addr));
                    end else begin
                        mon_w = wr_q.pop_front();
                        check("write_addr", {15'b0, mem_addr}, {15'b0, mon_w.idx});
                        check("write_data", mem_wdata, mon_w.data);
                    end
                end
                if (req_valid && !req_write && !stall) begin
                    if (ld_q.size() == 0) begin
                        flag("unexpected_load", "load with no expectation queued");
                    end else begin
                        mon_ld = ld_q.pop_front();
                        check("load_data", load_data, mon_ld);
                    end
                end
                if (!req_valid) check("idle_load_data", load_data, 32'h0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] ra;
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = (i < 64) ? $urandom : 32'h0;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h8899_AABB; ref_mem[0] = 32'h8899_AABB;

        // Load presented during reset must be gated off
        rst = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; req_valid = 1'b0;
        push_cyc(1'b0, 1'b0);

        issue(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h1, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h4, 32'h1234_5678);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h2, 32'h55);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h0, 32'h1111);
        issue(1'b1, 2'd1, 1'b0, 32'h2, 32'h2222);
        issue(1'b0, 2'd2, 1'b1, 32'h0, 32'h0);
        aborted_store(32'h1, 32'h77);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h6, 32'hCAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        issue(1'b0, 2'd3, 1'b1, 32'h4, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h3, 32'h0);

        for (int n = 0; n < 400; n++) begin
            // Small word range to force aliasing; random high bits exercise wrap
            ra = {$urandom_range(0, 8191), 19'b0} | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       idle();
                1:       aborted_store(ra, $urandom);
                2, 3, 4: issue(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom);
                default: issue(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom);
            endcase
        end

        idle();
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("cycle_queue_drained", cyc_q.size(), 32'h0);
        check("write_queue_drained", wr_q.size(), 32'h0);
        check("load_queue_drained", ld_q.size(), 32'h0);
        check("mem_word0_final", mem[0], ref_mem[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
